// File: rtl/wear_count_table_if.sv
// Bus bundle for wear_count_table: erase, read and scan signals.
// Optional WEAR_IRQ_EN adds wear_thresh/irq_clr/wear_irq.
interface wear_count_table_if #(
    parameter int BLOCKS = 64,
    parameter int CNT_W  = 16
);
    localparam int IDX_W = $clog2(BLOCKS);

    logic             erase_en;
    logic [IDX_W-1:0] erase_block;
    logic [IDX_W-1:0] rd_block;
    logic [CNT_W-1:0] rd_count;
    logic             scan_start;
    logic             scan_busy;
    logic             scan_done;
    logic             scan_stale;
    logic [IDX_W-1:0] min_block;
    logic [CNT_W-1:0] min_count;
    logic [IDX_W-1:0] max_block;
    logic [CNT_W-1:0] max_count;
    logic             sat_any;
`ifdef WEAR_IRQ_EN
    logic [CNT_W-1:0] wear_thresh;
    logic             irq_clr;
    logic             wear_irq;

    modport master (
        output erase_en, erase_block, rd_block, scan_start, wear_thresh, irq_clr,
        input  rd_count, scan_busy, scan_done, scan_stale, min_block, min_count,
               max_block, max_count, sat_any, wear_irq
    );
    modport slave (
        input  erase_en, erase_block, rd_block, scan_start, wear_thresh, irq_clr,
        output rd_count, scan_busy, scan_done, scan_stale, min_block, min_count,
               max_block, max_count, sat_any, wear_irq
    );
`else
    modport master (
        output erase_en, erase_block, rd_block, scan_start,
        input  rd_count, scan_busy, scan_done, scan_stale, min_block, min_count,
               max_block, max_count, sat_any
    );
    modport slave (
        input  erase_en, erase_block, rd_block, scan_start,
        output rd_count, scan_busy, scan_done, scan_stale, min_block, min_count,
               max_block, max_count, sat_any
    );
`endif
endinterface

// File: rtl/wear_count_table.sv
// Per-block saturating erase counters with registered read port, sticky saturation
// flag and sequential min/max scan. Optional WEAR_IRQ_EN adds a wear threshold interrupt.
module wear_count_table #(
    parameter int BLOCKS = 64,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    wear_count_table_if.slave bus
);
    localparam int               IDX_W    = $clog2(BLOCKS);
    localparam logic [IDX_W:0]   BLK_LIM  = (IDX_W+1)'(BLOCKS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BLOCKS - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_PRE  = CNT_MAX - 1'b1;

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t           r_state, w_state_next;
    logic [CNT_W-1:0] r_cnt [BLOCKS];
    logic [CNT_W-1:0] r_rd;
    logic             r_sat;
    logic [IDX_W-1:0] r_idx;
    logic [CNT_W-1:0] r_min, r_max, r_min_out, r_max_out;
    logic [IDX_W-1:0] r_min_blk, r_max_blk, r_min_blk_out, r_max_blk_out;
    logic             r_stale, r_stale_out;

    logic             w_erase_ok, w_rd_ok, w_inc, w_busy, w_done;
    logic             w_seed, w_min_take, w_max_take, w_stale_next;
    logic [CNT_W-1:0] w_cur, w_scan_val, w_min_next, w_max_next;
    logic [IDX_W-1:0] w_min_blk_next, w_max_blk_next;
    logic [BLOCKS-1:0] w_hit;

    assign w_erase_ok = bus.erase_en && ({1'b0, bus.erase_block} < BLK_LIM);
    assign w_rd_ok    = {1'b0, bus.rd_block} < BLK_LIM;
    assign w_cur      = r_cnt[bus.erase_block];
    assign w_inc      = w_erase_ok && (w_cur != CNT_MAX);

    genvar gi;
    generate
        for (gi = 0; gi < BLOCKS; gi++) begin : g_hit
            assign w_hit[gi] = w_inc && (bus.erase_block == IDX_W'(gi));
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < BLOCKS; i++) r_cnt[i] <= '0;
            r_rd  <= '0;
            r_sat <= 1'b0;
        end else begin
            for (int i = 0; i < BLOCKS; i++)
                if (w_hit[i]) r_cnt[i] <= r_cnt[i] + 1'b1;
            // Read samples the stored value, so a same-cycle erase is not visible yet
            r_rd <= w_rd_ok ? r_cnt[bus.rd_block] : '0;
            if (w_inc && (w_cur == CNT_PRE)) r_sat <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_busy       = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            IDLE: if (bus.scan_start) w_state_next = SCAN;
            SCAN: begin
                w_busy = 1'b1;
                if (r_idx == LAST_IDX) w_state_next = DONE;
            end
            DONE: begin
                w_done       = 1'b1;
                w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Strict compares keep the lowest index on ties
    assign w_scan_val     = r_cnt[r_idx];
    assign w_seed         = (r_idx == '0);
    assign w_min_take     = w_seed || (w_scan_val < r_min);
    assign w_max_take     = w_seed || (w_scan_val > r_max);
    assign w_min_next     = w_min_take ? w_scan_val : r_min;
    assign w_max_next     = w_max_take ? w_scan_val : r_max;
    assign w_min_blk_next = w_min_take ? r_idx : r_min_blk;
    assign w_max_blk_next = w_max_take ? r_idx : r_max_blk;
    assign w_stale_next   = r_stale | w_erase_ok;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_idx         <= '0;
            r_min         <= '0;
            r_max         <= '0;
            r_min_blk     <= '0;
            r_max_blk     <= '0;
            r_stale       <= 1'b0;
            r_min_out     <= '0;
            r_max_out     <= '0;
            r_min_blk_out <= '0;
            r_max_blk_out <= '0;
            r_stale_out   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (bus.scan_start) begin
                    r_idx   <= '0;
                    r_stale <= 1'b0;
                end
                SCAN: begin
                    r_idx     <= r_idx + 1'b1;
                    r_min     <= w_min_next;
                    r_max     <= w_max_next;
                    r_min_blk <= w_min_blk_next;
                    r_max_blk <= w_max_blk_next;
                    r_stale   <= w_stale_next;
                    // Publish on entry to DONE so results are valid alongside scan_done
                    if (r_idx == LAST_IDX) begin
                        r_min_out     <= w_min_next;
                        r_max_out     <= w_max_next;
                        r_min_blk_out <= w_min_blk_next;
                        r_max_blk_out <= w_max_blk_next;
                        r_stale_out   <= w_stale_next;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.rd_count   = r_rd;
    assign bus.sat_any    = r_sat;
    assign bus.scan_busy  = w_busy;
    assign bus.scan_done  = w_done;
    assign bus.scan_stale = r_stale_out;
    assign bus.min_block  = r_min_blk_out;
    assign bus.min_count  = r_min_out;
    assign bus.max_block  = r_max_blk_out;
    assign bus.max_count  = r_max_out;

`ifdef WEAR_IRQ_EN
    logic             r_irq;
    logic [CNT_W-1:0] w_post;

    assign w_post = w_inc ? w_cur + 1'b1 : w_cur;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)                                          r_irq <= 1'b0;
        else if (w_erase_ok && (w_post >= bus.wear_thresh)) r_irq <= 1'b1;
        else if (bus.irq_clr)                               r_irq <= 1'b0;
    end

    assign bus.wear_irq = r_irq;
`endif
endmodule
